indirect_target_predictor: RTL and testbench
============================================

# indirect_target_predictor

Parametrised successor to the fetch-stage JALR target table: a tagged, confidence-filtered indirect-jump target predictor with configurable fetch width, update-port count and table depth. It sits in the superscalar fetch stage, gives one target prediction for the earliest JALR in the fetch group, and takes resolved JALR outcomes from the execute/branch units. New behaviour:
- partial tags
- saturating confidence counters with hysteresis replacement
- a registered update buffer with lookup bypass
- a multi-cycle invalidate sweep

## Interface
- ADDR_WIDTH, 32, address/target width
- ENTRIES, 64, table entries; power of two, ≥ 4
- TAG_BITS, 8, partial tag width
- CONF_BITS, 2, confidence counter width
- FETCH_WIDTH, 5, lookup lanes
- UPDATE_PORTS, 3, resolve/update ports
- IDX = $clog2(ENTRIES); LW = $clog2(FETCH_WIDTH), min 1
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- lookup_pc_i  in  FETCH_WIDTH×ADDR_WIDTH  PC of each fetch lane
- is_jalr_i  in  FETCH_WIDTH  lane holds a JALR
- pred_valid_o  out  1  prediction available for the earliest JALR lane
- pred_target_o  out  ADDR_WIDTH  predicted target
- pred_lane_o  out  LW  lane index of the predicted JALR
- upd_valid_i  in  UPDATE_PORTS  port carries a resolved JALR
- upd_pc_i  in  UPDATE_PORTS×ADDR_WIDTH  PC of the JALR itself (not PC+4)
- upd_target_i  in  UPDATE_PORTS×ADDR_WIDTH  resolved target
- upd_mispredict_i  in  UPDATE_PORTS  front end predicted wrongly or not at all
- flush_i  in  1  request invalidation of the whole table
- busy_o  out  1  invalidate sweep in progress

## Operation
- Index = pc[IDX+1:2]. Tag = pc[IDX+TAG_BITS+1:IDX+2].
- Each entry holds valid, tag, target and conf (CONF_BITS).
- Lookup (combinational):
  - A lane hits when the entry is valid, its tag matches and conf ≠ 0.
  - The lowest lane with is_jalr_i=1 is selected. pred_lane_o = that lane; pred_valid_o = its hit; pred_target_o = its target.
  - With no JALR lane: pred_valid_o=0, pred_target_o=0, pred_lane_o=0.
- Update rule per port, applied to the entry as seen with pending-buffer bypass:
  - Tag hit, !mispredict: conf saturating +1; target unchanged.
  - Tag hit, mispredict, conf ≥ 2: conf −1; target kept (hysteresis).
  - Tag hit, mispredict, conf ≤ 1: target = upd_target_i, conf = 1.
  - Miss, mispredict: allocate with valid=1, new tag, target, conf=1.
  - Miss, !mispredict: no change.
- Same-index conflicts among valid ports in one cycle: lowest port number wins; the others are dropped.
- Flush FSM:
  - States are IDLE and SWEEP.
  - IDLE + flush_i → SWEEP, sweep counter = 0, pending buffer discarded.
  - In SWEEP: clear valid[counter] and conf[counter], counter +1. After clearing entry ENTRIES−1 → IDLE.
  - flush_i while in SWEEP is ignored.
  - While busy_o=1: pred_valid_o forced to 0 and all updates dropped.

## Timing
- Lookup is zero-latency, same cycle.
- Updates sampled at edge N go into the pending buffer. The table is written at edge N+1.
- Lookups and updates in cycle N+1 see the pending write through the bypass, so an update is visible one cycle after sampling.
- Flush asserted in cycle N: busy_o=1 from N+1 through N+ENTRIES inclusive; busy_o=0 and updates accepted again from N+ENTRIES+1.
- Reset, asynchronous active-low:
  - all valid and conf = 0, all targets and tags = 0
  - FSM = IDLE, counter = 0, pending buffer empty
  - pred_valid_o = 0, pred_target_o = 0, pred_lane_o = 0, busy_o = 0
- Reset asserted mid-sweep or mid-update aborts immediately to these reset values.

## Structure
- Package itp_pkg holds:
  - the itp_entry_t struct (valid, tag, target, conf), parametrised via package localparams overridden from the top
  - the itp_state_e enum {IDLE, SWEEP}
  - the CONF_MAX constant
- Sub-module itp_entry_next is combinational: current entry plus one update in, next entry out. It is instantiated once per update port.
- Priority encoding of lanes and ports stays in the top level.

## Test plan
- Reset, then lane 2 PC 0x108 is a JALR with an empty table → pred_valid_o=0, pred_lane_o=2.
- Update pc 0x108, target 0x4000, mispredict → next cycle, lookup of 0x108 in lane 0 gives valid=1, target 0x4000, conf=1.
- Two correct updates take conf to 3. One mispredict to 0x5000 → target stays 0x4000, conf=2. Two more mispredicts → target 0x5000, conf=1.
- Ports 0 and 2 both update index 5 in the same cycle with targets 0xA0 and 0xB0 → entry holds 0xA0. Also test a PC aliasing index 5 with a different tag → miss, no prediction.
- flush_i pulse with ENTRIES=64:
  - busy_o high exactly 64 cycles
  - pred_valid_o=0 throughout
  - updates dropped throughout
  - afterwards every lookup misses
- Drop reset low in sweep cycle 10 → busy_o=0 immediately; table empty after release.

Source files
------------

// File: rtl/itp_pkg.sv
// Shared types for the indirect target predictor: table entry layout, flush FSM states
// and the confidence ceiling. Entry field widths track the top-level parameter defaults.
package itp_pkg;

  localparam int ITP_ADDR_WIDTH = 32;
  localparam int ITP_TAG_BITS   = 8;
  localparam int ITP_CONF_BITS  = 2;

  localparam logic [ITP_CONF_BITS-1:0] CONF_MAX = '1;

  typedef struct packed {
    logic                      valid;
    logic [ITP_TAG_BITS-1:0]   tag;
    logic [ITP_ADDR_WIDTH-1:0] target;
    logic [ITP_CONF_BITS-1:0]  conf;
  } itp_entry_t;

  typedef enum logic {
    IDLE,
    SWEEP
  } itp_state_e;

endpackage

// File: rtl/itp_entry_next.sv
// Next-state of one table entry for one resolved JALR; purely combinational.
// Mispredicts on a confident entry only erode confidence before the target is replaced.
module itp_entry_next
  import itp_pkg::*;
(
  input  itp_entry_t                cur_i,
  input  logic [ITP_TAG_BITS-1:0]   tag_i,
  input  logic [ITP_ADDR_WIDTH-1:0] target_i,
  input  logic                      mispredict_i,
  output itp_entry_t                nxt_o
);

  logic hit;

  always_comb begin
    nxt_o = cur_i;
    hit   = cur_i.valid && (cur_i.tag == tag_i);
    if (hit) begin
      if (!mispredict_i) begin
        if (cur_i.conf != CONF_MAX) nxt_o.conf = cur_i.conf + 1'b1;
      end else if (cur_i.conf >= ITP_CONF_BITS'(2)) begin
        nxt_o.conf = cur_i.conf - 1'b1;
      end else begin
        nxt_o.target = target_i;
        nxt_o.conf   = ITP_CONF_BITS'(1);
      end
    end else if (mispredict_i) begin
      nxt_o.valid  = 1'b1;
      nxt_o.tag    = tag_i;
      nxt_o.target = target_i;
      nxt_o.conf   = ITP_CONF_BITS'(1);
    end
  end

endmodule

// File: rtl/indirect_target_predictor.sv
// Tagged indirect-jump target predictor: zero-latency lookup for the earliest JALR lane,
// updates land one edge later in a pending buffer that lookups bypass; flush sweeps the table.
module indirect_target_predictor
  import itp_pkg::*;
#(
  parameter int ADDR_WIDTH   = ITP_ADDR_WIDTH,
  parameter int ENTRIES      = 64,
  parameter int TAG_BITS     = ITP_TAG_BITS,
  parameter int CONF_BITS    = ITP_CONF_BITS,
  parameter int FETCH_WIDTH  = 5,
  parameter int UPDATE_PORTS = 3,
  localparam int IDX = $clog2(ENTRIES),
  localparam int LW  = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0]  lookup_pc_i,
  input  logic [FETCH_WIDTH-1:0]             is_jalr_i,
  output logic                               pred_valid_o,
  output logic [ADDR_WIDTH-1:0]              pred_target_o,
  output logic [LW-1:0]                      pred_lane_o,
  input  logic [UPDATE_PORTS-1:0]            upd_valid_i,
  input  logic [UPDATE_PORTS*ADDR_WIDTH-1:0] upd_pc_i,
  input  logic [UPDATE_PORTS*ADDR_WIDTH-1:0] upd_target_i,
  input  logic [UPDATE_PORTS-1:0]            upd_mispredict_i,
  input  logic                               flush_i,
  output logic                               busy_o
);

  itp_entry_t              tbl_q [ENTRIES];
  logic [UPDATE_PORTS-1:0] pend_vld_q, pend_vld_d;
  logic [IDX-1:0]          pend_idx_q [UPDATE_PORTS];
  itp_entry_t              pend_ent_q [UPDATE_PORTS];
  itp_state_e              state_q, state_d;
  logic [IDX-1:0]          cnt_q, cnt_d;

  logic [IDX-1:0]          upd_idx [UPDATE_PORTS];
  logic [TAG_BITS-1:0]     upd_tag [UPDATE_PORTS];
  itp_entry_t              upd_cur [UPDATE_PORTS];
  itp_entry_t              upd_nxt [UPDATE_PORTS];
  logic [UPDATE_PORTS-1:0] upd_win;
  logic                    unused_pc_bits;

  assign unused_pc_bits = ^{lookup_pc_i, upd_pc_i};
  assign busy_o         = (state_q == SWEEP);

  // Pending indices are unique (same-index conflicts are resolved before capture).
  function automatic itp_entry_t view_f(input logic [IDX-1:0] idx);
    itp_entry_t e;
    e = tbl_q[idx];
    for (int p = 0; p < UPDATE_PORTS; p++)
      if (pend_vld_q[p] && (pend_idx_q[p] == idx)) e = pend_ent_q[p];
    return e;
  endfunction

  always_comb begin
    itp_entry_t e;
    logic       found;
    e             = '0;
    found         = 1'b0;
    pred_valid_o  = 1'b0;
    pred_target_o = '0;
    pred_lane_o   = '0;
    for (int l = 0; l < FETCH_WIDTH; l++) begin
      if (is_jalr_i[l] && !found) begin
        found        = 1'b1;
        e            = view_f(lookup_pc_i[l*ADDR_WIDTH+2 +: IDX]);
        pred_lane_o  = LW'(l);
        pred_valid_o = e.valid && (e.conf != '0) && (state_q == IDLE) &&
                       (e.tag == lookup_pc_i[l*ADDR_WIDTH+IDX+2 +: TAG_BITS]);
        if (pred_valid_o) pred_target_o = e.target;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < UPDATE_PORTS; p++) begin
      upd_idx[p] = upd_pc_i[p*ADDR_WIDTH+2 +: IDX];
      upd_tag[p] = upd_pc_i[p*ADDR_WIDTH+IDX+2 +: TAG_BITS];
      upd_cur[p] = view_f(upd_idx[p]);
    end
    upd_win = '0;
    for (int p = 0; p < UPDATE_PORTS; p++) begin
      upd_win[p] = upd_valid_i[p] && (state_q == IDLE);
      for (int q = 0; q < UPDATE_PORTS; q++)
        if ((q < p) && upd_valid_i[q] && (upd_idx[q] == upd_idx[p])) upd_win[p] = 1'b0;
    end
    pend_vld_d = flush_i ? '0 : upd_win;
  end

  for (genvar p = 0; p < UPDATE_PORTS; p++) begin : g_upd
    itp_entry_next u_next (
      .cur_i       (upd_cur[p]),
      .tag_i       (upd_tag[p]),
      .target_i    (upd_target_i[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .mispredict_i(upd_mispredict_i[p]),
      .nxt_o       (upd_nxt[p])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (flush_i) begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX'(ENTRIES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_vld_q <= '0;
      for (int p = 0; p < UPDATE_PORTS; p++) begin
        pend_idx_q[p] <= '0;
        pend_ent_q[p] <= '0;
      end
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
      for (int p = 0; p < UPDATE_PORTS; p++) begin
        pend_idx_q[p] <= upd_idx[p];
        pend_ent_q[p] <= upd_nxt[p];
      end
      // A flush discards whatever is still pending instead of committing it.
      if ((state_q == IDLE) && !flush_i) begin
        for (int p = 0; p < UPDATE_PORTS; p++)
          if (pend_vld_q[p]) tbl_q[pend_idx_q[p]] <= pend_ent_q[p];
      end
      if (state_q == SWEEP) begin
        tbl_q[cnt_q].valid <= 1'b0;
        tbl_q[cnt_q].conf  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_indirect_target_predictor.sv
// Self-checking bench: lookup vector table plus hand sequences for hysteresis, port conflicts,
// flush sweep and mid-sweep reset; expected predictions go through a scoreboard queue.
module tb_indirect_target_predictor;
  localparam int AW  = 32;
  localparam int ENT = 64;
  localparam int FW  = 5;
  localparam int UP  = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [FW*AW-1:0]  lookup_pc_i = '0;
  logic [FW-1:0]     is_jalr_i = '0;
  logic              pred_valid_o;
  logic [AW-1:0]     pred_target_o;
  logic [2:0]        pred_lane_o;
  logic [UP-1:0]     upd_valid_i = '0;
  logic [UP*AW-1:0]  upd_pc_i = '0;
  logic [UP*AW-1:0]  upd_target_i = '0;
  logic [UP-1:0]     upd_mispredict_i = '0;
  logic              flush_i = 1'b0;
  logic              busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       nm;
    bit          vld;
    int          lane;
    logic [AW-1:0] tgt;
    bit          chk_tgt;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [FW*AW-1:0] pcs;
    logic [FW-1:0]    jalr;
    bit               vld;
    int               lane;
    logic [AW-1:0]    tgt;
  } vec_t;
  vec_t vecs[8];

  indirect_target_predictor #(
    .ADDR_WIDTH(AW), .ENTRIES(ENT), .TAG_BITS(8), .CONF_BITS(2),
    .FETCH_WIDTH(FW), .UPDATE_PORTS(UP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .lookup_pc_i     (lookup_pc_i),
    .is_jalr_i       (is_jalr_i),
    .pred_valid_o    (pred_valid_o),
    .pred_target_o   (pred_target_o),
    .pred_lane_o     (pred_lane_o),
    .upd_valid_i     (upd_valid_i),
    .upd_pc_i        (upd_pc_i),
    .upd_target_i    (upd_target_i),
    .upd_mispredict_i(upd_mispredict_i),
    .flush_i         (flush_i),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input int p, input logic [AW-1:0] pc, input logic [AW-1:0] tgt, input bit mis);
    upd_valid_i[p]          = 1'b1;
    upd_pc_i[p*AW +: AW]     = pc;
    upd_target_i[p*AW +: AW] = tgt;
    upd_mispredict_i[p]     = mis;
  endtask

  task automatic upd_clear();
    upd_valid_i      = '0;
    upd_pc_i         = '0;
    upd_target_i     = '0;
    upd_mispredict_i = '0;
  endtask

  task automatic compare_pred();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({e.nm, "_vld"}, 64'(pred_valid_o), 64'(e.vld));
    chk({e.nm, "_lane"}, 64'(pred_lane_o), 64'(e.lane));
    if (e.vld || e.chk_tgt) chk({e.nm, "_tgt"}, 64'(pred_target_o), 64'(e.tgt));
  endtask

  task automatic look(input string nm, input logic [FW*AW-1:0] pcs, input logic [FW-1:0] jalr,
                      input bit vld, input int lane, input logic [AW-1:0] tgt);
    exp_t e;
    lookup_pc_i = pcs;
    is_jalr_i   = jalr;
    e.nm = nm; e.vld = vld; e.lane = lane; e.tgt = tgt; e.chk_tgt = (jalr == '0);
    exp_q.push_back(e);
    #1;
    compare_pred();
  endtask

  task automatic look0(input string nm, input logic [AW-1:0] pc, input bit vld, input logic [AW-1:0] tgt);
    look(nm, {128'h0, pc}, 5'b00001, vld, 0, tgt);
  endtask

  initial begin
    vecs[0] = '{{32'h108, 32'h108, 32'h108, 32'h108, 32'h108}, 5'b00000, 1'b0, 0, 32'h0};
    vecs[1] = '{{32'h0, 32'h0, 32'h0, 32'h0, 32'h108},         5'b00001, 1'b1, 0, 32'h5000};
    vecs[2] = '{{32'h108, 32'h114, 32'h108, 32'h108, 32'h108}, 5'b11000, 1'b1, 3, 32'hA0};
    vecs[3] = '{{32'h0, 32'h0, 32'h108, 32'h214, 32'h108},     5'b00110, 1'b0, 1, 32'h0};
    vecs[4] = '{{32'h108, 32'h0, 32'h0, 32'h0, 32'h0},         5'b10000, 1'b1, 4, 32'h5000};
    vecs[5] = '{{32'h0, 32'h0, 32'h0, 32'h0, 32'h10C},         5'b00001, 1'b0, 0, 32'h0};
    vecs[6] = '{{32'h0, 32'h0, 32'h00010108, 32'h0, 32'h0},    5'b00100, 1'b1, 2, 32'h5000};
    vecs[7] = '{{32'h108, 32'h108, 32'h108, 32'h114, 32'h108}, 5'b11110, 1'b1, 1, 32'hA0};

    // Reset values
    #2;
    look("reset_idle", '0, '0, 1'b0, 0, 32'h0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    step();
    step();
    reset = 1'b1;
    step();

    look("empty_lane2", {64'h0, 32'h108, 64'h0}, 5'b00100, 1'b0, 2, 32'h0);

    // Allocation, visible exactly one cycle after sampling
    upd(0, 32'h108, 32'h4000, 1'b1);
    look0("alloc_same_cycle", 32'h108, 1'b0, 32'h0);
    step();
    upd_clear();
    look0("alloc_next_cycle", 32'h108, 1'b1, 32'h4000);

    // Back-to-back correct updates chain through the bypass: conf 1 -> 3
    upd(0, 32'h108, 32'h0, 1'b0);
    step();
    upd(1, 32'h108, 32'h0, 1'b0);
    step();
    upd_clear();
    look0("conf3_target", 32'h108, 1'b1, 32'h4000);

    // Hysteresis: 3 -> 2 -> 1 keep target, then replace with conf 1
    upd(2, 32'h108, 32'h5000, 1'b1);
    step();
    upd_clear();
    look0("mis1_keep", 32'h108, 1'b1, 32'h4000);
    upd(0, 32'h108, 32'h5000, 1'b1);
    step();
    upd_clear();
    look0("mis2_keep", 32'h108, 1'b1, 32'h4000);
    upd(0, 32'h108, 32'h5000, 1'b1);
    step();
    upd_clear();
    look0("mis3_replace", 32'h108, 1'b1, 32'h5000);

    // Same-index conflict: lowest port wins
    upd(0, 32'h114, 32'hA0, 1'b1);
    upd(2, 32'h114, 32'hB0, 1'b1);
    step();
    upd_clear();
    look0("conflict_bypass", 32'h114, 1'b1, 32'hA0);
    step();
    look0("conflict_table", 32'h114, 1'b1, 32'hA0);
    look0("alias_idx5", 32'h214, 1'b0, 32'h0);
    step();

    for (int i = 0; i < 8; i++) begin
      look($sformatf("vec%0d", i), vecs[i].pcs, vecs[i].jalr, vecs[i].vld, vecs[i].lane, vecs[i].tgt);
      step();
    end

    // Flush: pending update discarded, 64 busy cycles, updates and flush ignored meanwhile
    flush_i = 1'b1;
    upd(0, 32'h118, 32'h99, 1'b1);
    chk("flush_req_busy", 64'(busy_o), 64'd0);
    step();
    flush_i = 1'b0;
    upd_clear();
    for (int i = 0; i < ENT; i++) begin
      chk($sformatf("sweep%0d_busy", i), 64'(busy_o), 64'd1);
      flush_i = (i == 30);
      upd(1, 32'h10C, 32'h777, 1'b1);
      look0($sformatf("sweep%0d", i), 32'h108, 1'b0, 32'h0);
      step();
    end
    flush_i = 1'b0;
    upd_clear();
    chk("post_sweep_busy", 64'(busy_o), 64'd0);
    look0("post_sweep_108", 32'h108, 1'b0, 32'h0);
    look0("post_sweep_114", 32'h114, 1'b0, 32'h0);
    look0("post_sweep_10c", 32'h10C, 1'b0, 32'h0);
    look0("post_sweep_118", 32'h118, 1'b0, 32'h0);
    upd(0, 32'h108, 32'h6000, 1'b1);
    step();
    upd_clear();
    chk("post_sweep_still_idle", 64'(busy_o), 64'd0);
    look0("post_sweep_update", 32'h108, 1'b1, 32'h6000);

    // Reset in sweep cycle 10 aborts, and the table stays empty
    upd(0, 32'h1A0, 32'h1234, 1'b1);
    step();
    upd_clear();
    look0("pre_reset_1a0", 32'h1A0, 1'b1, 32'h1234);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    repeat (10) step();
    chk("sweep10_busy", 64'(busy_o), 64'd1);
    reset = 1'b0;
    #1;
    chk("reset_mid_sweep_busy", 64'(busy_o), 64'd0);
    look0("reset_mid_sweep_pred", 32'h1A0, 1'b0, 32'h0);
    step();
    step();
    reset = 1'b1;
    look0("after_reset_1a0", 32'h1A0, 1'b0, 32'h0);
    look0("after_reset_108", 32'h108, 1'b0, 32'h0);
    chk("after_reset_busy", 64'(busy_o), 64'd0);
    upd(0, 32'h1A0, 32'h55, 1'b1);
    step();
    upd_clear();
    look0("after_reset_update", 32'h1A0, 1'b1, 32'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
